pdec_sort_ctrl: RTL and testbench

- Multi-cycle 16-entry bitonic sorter for the polar decoder path-metric list.
- Sits directly upstream of, and drives, a single shared pdec_sort_unit instance (8 compare-exchange lanes, per-pair direction via sort_ind).
- Each pass permutes the working vector into 8 pairs, applies the unit, and writes the result back.
- 10 passes produce a fully sorted metric/index vector, returned through a valid/ready handshake.

---
 rtl/pdec_sort_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pdec_sort_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pdec_sort_ctrl.sv
// Multi-cycle 16-entry bitonic sorter for the polar decoder path-metric list.
// One shared 8-lane compare-exchange unit is reused across the 10 network passes.

module pdec_sort_unit #(
   parameter int WID_D = 10,
   parameter int WID_I = 5
) (
   input  logic [7:0]         sort_ind,
   input  logic [8*WID_D-1:0] data0,
   input  logic [8*WID_D-1:0] data1,
   input  logic [8*WID_I-1:0] idx0,
   input  logic [8*WID_I-1:0] idx1,
   output logic [8*WID_D-1:0] res_data0,
   output logic [8*WID_D-1:0] res_data1,
   output logic [8*WID_I-1:0] res_idx0,
   output logic [8*WID_I-1:0] res_idx1
);

   // sort_ind 0 leaves the larger metric on lane 0, 1 the smaller; ties never swap.
   for (genvar p = 0; p < 8; p++) begin : g_lane
      logic [WID_D-1:0] a;
      logic [WID_D-1:0] b;
      logic             swap;

      assign a    = data0[p*WID_D +: WID_D];
      assign b    = data1[p*WID_D +: WID_D];
      assign swap = sort_ind[p] ? (a > b) : (a < b);

      assign res_data0[p*WID_D +: WID_D] = swap ? b : a;
      assign res_data1[p*WID_D +: WID_D] = swap ? a : b;
      assign res_idx0[p*WID_I +: WID_I]  = swap ? idx1[p*WID_I +: WID_I] : idx0[p*WID_I +: WID_I];
      assign res_idx1[p*WID_I +: WID_I]  = swap ? idx0[p*WID_I +: WID_I] : idx1[p*WID_I +: WID_I];
   end

endmodule

module pdec_sort_ctrl #(
   parameter int WID_D = 10,
   parameter int WID_I = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_vld,
   output logic                in_rdy,
   input  logic [WID_D*16-1:0] in_data,
   input  logic [WID_I*16-1:0] in_idx,
   input  logic                in_mode,
   output logic                out_vld,
   input  logic                out_rdy,
   output logic [WID_D*16-1:0] out_data,
   output logic [WID_I*16-1:0] out_idx
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       pass_cnt;
   logic             mode_r;
   logic [WID_D-1:0] work_d [16];
   logic [WID_I-1:0] work_i [16];
   logic [WID_D-1:0] next_d [16];
   logic [WID_I-1:0] next_i [16];

   logic [1:0]       jb;
   logic [2:0]       kb;
   logic [3:0]       j_mask;
   logic [4:0]       k_mask;
   logic [3:0]       lo_ent [8];
   logic [3:0]       hi_ent [8];
   logic [7:0]       sort_ind;
   logic [8*WID_D-1:0] lane_d0, lane_d1, res_d0, res_d1;
   logic [8*WID_I-1:0] lane_i0, lane_i1, res_i0, res_i1;

   // Pass schedule: log2(j) and log2(k) for each network stage.
   always_comb begin
      jb = 2'd0;
      kb = 3'd4;
      case (pass_cnt)
         4'd0: begin jb = 2'd0; kb = 3'd1; end
         4'd1: begin jb = 2'd1; kb = 3'd2; end
         4'd2: begin jb = 2'd0; kb = 3'd2; end
         4'd3: begin jb = 2'd2; kb = 3'd3; end
         4'd4: begin jb = 2'd1; kb = 3'd3; end
         4'd5: begin jb = 2'd0; kb = 3'd3; end
         4'd6: begin jb = 2'd3; kb = 3'd4; end
         4'd7: begin jb = 2'd2; kb = 3'd4; end
         4'd8: begin jb = 2'd1; kb = 3'd4; end
         4'd9: begin jb = 2'd0; kb = 3'd4; end
         default: begin jb = 2'd0; kb = 3'd4; end
      endcase
      j_mask = 4'd1 << jb;
      k_mask = 5'd1 << kb;
   end

   // Lower entry of pair p is p with a zero inserted at bit position log2(j).
   always_comb begin
      lo_ent   = '{default: '0};
      hi_ent   = '{default: '0};
      sort_ind = '0;
      lane_d0  = '0;
      lane_d1  = '0;
      lane_i0  = '0;
      lane_i1  = '0;
      for (int p = 0; p < 8; p++) begin
         case (jb)
            2'd0:    lo_ent[p] = {p[2:0], 1'b0};
            2'd1:    lo_ent[p] = {p[2:1], 1'b0, p[0]};
            2'd2:    lo_ent[p] = {p[2], 1'b0, p[1:0]};
            default: lo_ent[p] = {1'b0, p[2:0]};
         endcase
         hi_ent[p]   = lo_ent[p] | j_mask;
         sort_ind[p] = mode_r ^ (|({1'b0, lo_ent[p]} & k_mask));
         lane_d0[p*WID_D +: WID_D] = work_d[lo_ent[p]];
         lane_d1[p*WID_D +: WID_D] = work_d[hi_ent[p]];
         lane_i0[p*WID_I +: WID_I] = work_i[lo_ent[p]];
         lane_i1[p*WID_I +: WID_I] = work_i[hi_ent[p]];
      end
   end

   pdec_sort_unit #(.WID_D(WID_D), .WID_I(WID_I)) u_sort_unit (
      .sort_ind  (sort_ind),
      .data0     (lane_d0),
      .data1     (lane_d1),
      .idx0      (lane_i0),
      .idx1      (lane_i1),
      .res_data0 (res_d0),
      .res_data1 (res_d1),
      .res_idx0  (res_i0),
      .res_idx1  (res_i1)
   );

   always_comb begin
      next_d = work_d;
      next_i = work_i;
      for (int p = 0; p < 8; p++) begin
         next_d[lo_ent[p]] = res_d0[p*WID_D +: WID_D];
         next_d[hi_ent[p]] = res_d1[p*WID_D +: WID_D];
         next_i[lo_ent[p]] = res_i0[p*WID_I +: WID_I];
         next_i[hi_ent[p]] = res_i1[p*WID_I +: WID_I];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pass_cnt <= '0;
         mode_r   <= 1'b0;
         work_d   <= '{default: '0};
         work_i   <= '{default: '0};
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_vld) begin
            pass_cnt <= '0;
            mode_r   <= in_mode;
            for (int e = 0; e < 16; e++) begin
               work_d[e] <= in_data[e*WID_D +: WID_D];
               work_i[e] <= in_idx[e*WID_I +: WID_I];
            end
         end else if (state == RUN) begin
            pass_cnt <= pass_cnt + 4'd1;
            work_d   <= next_d;
            work_i   <= next_i;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      in_rdy    = 1'b0;
      out_vld   = 1'b0;
      case (state)
         IDLE: begin
            in_rdy = 1'b1;
            if (in_vld) state_nxt = RUN;
         end
         RUN: begin
            if (pass_cnt == 4'd9) state_nxt = DONE;
         end
         DONE: begin
            out_vld = 1'b1;
            if (out_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_data = '0;
      out_idx  = '0;
      for (int e = 0; e < 16; e++) begin
         out_data[e*WID_D +: WID_D] = work_d[e];
         out_idx[e*WID_I +: WID_I]  = work_i[e];
      end
   end

endmodule

// File: tb/tb_pdec_sort_ctrl.sv
// Directed self-checking bench for pdec_sort_ctrl: ordering, ties, backpressure,
// asynchronous abort and back-to-back throughput.

module tb_pdec_sort_ctrl;

   localparam int WD = 10;
   localparam int WI = 5;

   logic             clk;
   logic             rst_n;
   logic             in_vld;
   logic             in_rdy;
   logic [WD*16-1:0] in_data;
   logic [WI*16-1:0] in_idx;
   logic             in_mode;
   logic             out_vld;
   logic             out_rdy;
   logic [WD*16-1:0] out_data;
   logic [WI*16-1:0] out_idx;

   int compared;
   int mismatched;

   int asc_d[16]      = '{15, 3, 9, 0, 12, 7, 1, 14, 5, 10, 2, 8, 13, 4, 11, 6};
   int asc_exp_i[16]  = '{3, 6, 10, 1, 13, 8, 15, 5, 11, 2, 9, 14, 4, 12, 7, 0};
   int desc_exp_i[16] = '{0, 7, 12, 4, 14, 9, 2, 11, 5, 15, 8, 13, 1, 10, 6, 3};
   int ramp[16]       = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
   int rev[16]        = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
   int ties[16]       = '{100, 100, 100, 100, 100, 100, 100, 100,
                          100, 100, 100, 100, 100, 100, 100, 100};

   pdec_sort_ctrl #(.WID_D(WD), .WID_I(WI)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_data  (in_data),
      .in_idx   (in_idx),
      .in_mode  (in_mode),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .out_idx  (out_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WD*16-1:0] packD(input int v[16]);
      logic [WD*16-1:0] r;
      r = '0;
      for (int e = 0; e < 16; e++) r[e*WD +: WD] = WD'(v[e]);
      return r;
   endfunction

   function automatic logic [WI*16-1:0] packI(input int v[16]);
      logic [WI*16-1:0] r;
      r = '0;
      for (int e = 0; e < 16; e++) r[e*WI +: WI] = WI'(v[e]);
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [WD*16-1:0] obs,
                              input logic [WD*16-1:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int d[16], input int ix[16], input logic mode);
      in_data = packD(d);
      in_idx  = packI(ix);
      in_mode = mode;
      in_vld  = 1'b1;
   endtask

   // Counts falling edges from the drive point until out_vld is seen, bounded.
   task automatic waitOut(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) in_vld = 1'b0;
      end while (!out_vld && cyc < 40);
   endtask

   int cyc;
   int gap;
   logic [WD*16-1:0] held_d;

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n   = 1'b0;
      in_vld  = 1'b0;
      in_data = '0;
      in_idx  = '0;
      in_mode = 1'b0;
      out_rdy = 1'b1;
      #12;
      checkOutput("reset_in_rdy", 160'(in_rdy), 160'(1));
      checkOutput("reset_out_vld", 160'(out_vld), 160'(0));
      checkOutput("reset_out_data", out_data, '0);
      checkOutput("reset_out_idx", 160'(out_idx), '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Descending order of a ramp.
      applyStimulus(ramp, ramp, 1'b0);
      waitOut(cyc);
      checkOutput("desc_latency", 160'(cyc), 160'(11));
      checkOutput("desc_data", out_data, packD(rev));
      checkOutput("desc_idx", 160'(out_idx), 160'(packI(rev)));
      @(negedge clk);
      checkOutput("desc_post_in_rdy", 160'(in_rdy), 160'(1));
      checkOutput("desc_post_out_vld", 160'(out_vld), 160'(0));

      // Ascending order of a scrambled vector.
      applyStimulus(asc_d, ramp, 1'b1);
      waitOut(cyc);
      checkOutput("asc_latency", 160'(cyc), 160'(11));
      checkOutput("asc_data", out_data, packD(ramp));
      checkOutput("asc_idx", 160'(out_idx), 160'(packI(asc_exp_i)));
      @(negedge clk);

      // All metrics equal: nothing may move.
      applyStimulus(ties, ramp, 1'b1);
      waitOut(cyc);
      checkOutput("ties_data", out_data, packD(ties));
      checkOutput("ties_idx", 160'(out_idx), 160'(packI(ramp)));
      @(negedge clk);

      // Backpressure with stray in_vld pulses.
      out_rdy = 1'b0;
      applyStimulus(ramp, ramp, 1'b1);
      waitOut(cyc);
      checkOutput("bp_data", out_data, packD(ramp));
      held_d = out_data;
      for (int c = 0; c < 5; c++) begin
         in_vld  = c[0];
         in_data = packD(rev);
         @(negedge clk);
         checkOutput("bp_out_vld_held", 160'(out_vld), 160'(1));
         checkOutput("bp_in_rdy_low", 160'(in_rdy), 160'(0));
         checkOutput("bp_data_stable", out_data, held_d);
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_in_rdy", 160'(in_rdy), 160'(1));
      checkOutput("bp_release_out_vld", 160'(out_vld), 160'(0));

      // Abort while pass_cnt is 5.
      applyStimulus(ramp, ramp, 1'b0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         in_vld = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("abort_in_rdy", 160'(in_rdy), 160'(1));
      checkOutput("abort_out_vld", 160'(out_vld), 160'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(asc_d, ramp, 1'b1);
      waitOut(cyc);
      checkOutput("abort_latency", 160'(cyc), 160'(11));
      checkOutput("abort_data", out_data, packD(ramp));
      checkOutput("abort_idx", 160'(out_idx), 160'(packI(asc_exp_i)));
      @(negedge clk);

      // Back-to-back with in_vld held; second vector's mode must not leak into the first.
      applyStimulus(asc_d, ramp, 1'b0);
      @(negedge clk);
      checkOutput("b2b_first_accepted", 160'(in_rdy), 160'(0));
      applyStimulus(ramp, ramp, 1'b1);
      cyc = 1;
      while (!out_vld && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("b2b_first_latency", 160'(cyc), 160'(11));
      checkOutput("b2b_first_data", out_data, packD(rev));
      checkOutput("b2b_first_idx", 160'(out_idx), 160'(packI(desc_exp_i)));
      @(negedge clk);
      checkOutput("b2b_second_offered", 160'(in_rdy), 160'(1));
      gap = 1;
      @(negedge clk);
      gap++;
      in_vld = 1'b0;
      checkOutput("b2b_second_accepted", 160'(in_rdy), 160'(0));
      while (!out_vld && gap < 40) begin
         @(negedge clk);
         gap++;
      end
      checkOutput("b2b_spacing", 160'(gap), 160'(12));
      checkOutput("b2b_second_data", out_data, packD(ramp));
      checkOutput("b2b_second_idx", 160'(out_idx), 160'(packI(ramp)));
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
